o_drain_ctrl: RTL and testbench
===============================

# o_drain_ctrl

Output-drain sequencer for the systolic-array accelerator. After a compute pass, the top-level FSM pulses `start`. This block then walks every one of the ARRAY_M output-buffer RAMs over a row range and issues one local read per cycle. Each returned word is written to O_BRAM at a linearly increasing byte address, and `done` pulses when the last write has been issued. It sits between the top-level FSM, the O_buffer read port (`o_drain`, `o_ram_idx`, `o_read_addr`) and the O_BRAM port.

## Interface
Parameters:
- ARRAY_M, 8: number of output-buffer RAMs (columns)
- RAM_SIZE, 1024: depth of each output-buffer RAM
- ADDR_WIDTH, $clog2(RAM_SIZE): local RAM address width
- OUT_WIDTH, 32: data word width; only 32 is supported

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- o_base_addr  in  ADDR_WIDTH  first local row address; latched at start
- num_rows  in  ADDR_WIDTH+1  number of rows to drain, 0..RAM_SIZE; latched at start
- bram_base  in  32  O_BRAM byte base address; latched at start
- o_drain  out  1  read strobe to the O_buffer
- o_ram_idx  out  $clog2(ARRAY_M)  RAM select
- o_read_addr  out  ADDR_WIDTH  local read address
- o_rdata  in  OUT_WIDTH  read data, valid exactly 1 cycle after o_drain
- addr_o_bram  out  32  O_BRAM byte address
- enable_o_bram  out  1  O_BRAM enable
- w_enable_o_bram  out  4  byte write enables: 4'hF when writing, else 0
- data_in_o_bram  out  32  write data; combinational pass-through of o_rdata
- busy  out  1  high from the cycle after start acceptance until the final write
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, FLUSH, DONE.
- IDLE, start=1, num_rows>0: latch the three inputs and go to READ. IDLE, start=1, num_rows=0: go to DONE with no reads or writes.
- READ: each cycle issue one read with o_drain=1. Iteration is row-major:
  - o_ram_idx steps 0..ARRAY_M-1 and then wraps to 0.
  - On that wrap, the row counter r increments.
  - o_read_addr = (o_base_addr + r) mod 2^ADDR_WIDTH, so the row address wraps past RAM_SIZE-1 to 0.
- READ exit: after the read of row num_rows-1, RAM ARRAY_M-1, go to FLUSH. Total reads N = num_rows*ARRAY_M.
- Write pipeline: every read is followed one cycle later by a write.
  - enable_o_bram=1 and w_enable_o_bram=4'hF on that cycle.
  - addr_o_bram = bram_base + 4*k, where k is the 0-based read index, mod 2^32.
- FLUSH: o_drain=0; the last write is issued; go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored and is not queued.
- All control outputs (o_drain, o_ram_idx, o_read_addr, addr_o_bram, enable_o_bram, w_enable_o_bram, busy, done) are registered. data_in_o_bram is the only combinational output.
- Reset values: state IDLE; all counters and every registered output 0; data_in_o_bram follows o_rdata.
- Reset mid-operation: on the next edge, return to IDLE. No further reads or writes are issued and no done pulse is produced.

## Timing
Let C be the cycle in which start is sampled in IDLE:
- C+1..C+N: o_drain=1, busy=1; read index k is issued at C+1+k.
- C+2..C+N+1: enable_o_bram=1; write k occurs at C+2+k.
- C+N+1: FLUSH; o_drain=0, busy=1.
- C+N+2: done=1, busy=0.
- C+N+3: IDLE; the earliest next start is sampled here.
- num_rows=0: done=1 at C+1; busy stays 0 throughout.
- Throughput is one word per cycle, with no bubbles between rows.

## Test plan
- Basic drain: ARRAY_M=8, o_base_addr=5, num_rows=2, bram_base=0x100, o_rdata = {ram_idx, addr}.
  - Required: 16 writes at 0x100..0x13C in steps of 4.
  - The data sequence is ram 0..7 at addr 5, then ram 0..7 at addr 6.
  - done=1 exactly at C+18, and enable_o_bram=1 for exactly 16 cycles.
- Address wrap: o_base_addr=1022, num_rows=3. Required: o_read_addr runs 1022 (×8), 1023 (×8), 0 (×8); 24 writes.
- Zero rows: num_rows=0. Required: done at C+1, no o_drain, no enable_o_bram, busy never high.
- Start while busy: re-pulse start at C+5 with different inputs. Required: it is ignored; the original sequence completes unchanged and there is exactly one done pulse.
- Reset mid-drain: assert reset at C+6. Required: all outputs 0 on the following cycle, no done pulse, no writes afterwards.
- Back-to-back: issue a second start at C+N+3, the first IDLE cycle. Required: it is accepted, a second full sequence runs and done pulses again.

Source files
------------

// File: rtl/o_drain_ctrl.sv
// Output-drain sequencer: walks all ARRAY_M output-buffer RAMs row-major over a
// row range and copies each returned word to O_BRAM at a linearly rising address.
module o_drain_ctrl #(
  parameter int ARRAY_M    = 8,
  parameter int RAM_SIZE   = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int OUT_WIDTH  = 32,
  localparam int IDX_W     = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] o_base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic [31:0]           bram_base,
  output logic                  o_drain,
  output logic [IDX_W-1:0]      o_ram_idx,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  input  logic [OUT_WIDTH-1:0]  o_rdata,
  output logic [31:0]           addr_o_bram,
  output logic                  enable_o_bram,
  output logic [3:0]            w_enable_o_bram,
  output logic [31:0]           data_in_o_bram,
  output logic                  busy,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | one O_buffer read per cycle, row-major over RAMs
  // FLUSH | no read; last write of the pipeline is issued
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t state_q, state_d;

  logic                  o_drain_q, o_drain_d;
  logic [IDX_W-1:0]      ram_idx_q, ram_idx_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]   rows_left_q, rows_left_d;
  logic [31:0]           wptr_q, wptr_d;
  logic [31:0]           wr_addr_q, wr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic last_rd;
  logic accept;
  logic idx_wrap;

  assign idx_wrap = (ram_idx_q == IDX_W'(ARRAY_M - 1));
  assign last_rd  = (state_q == READ) && idx_wrap && (rows_left_q == '0);
  assign accept   = (state_q == IDLE) && start && (num_rows != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      o_drain_q   <= 1'b0;
      ram_idx_q   <= '0;
      rd_addr_q   <= '0;
      rows_left_q <= '0;
      wptr_q      <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_drain_q   <= o_drain_d;
      ram_idx_q   <= ram_idx_d;
      rd_addr_q   <= rd_addr_d;
      rows_left_q <= rows_left_d;
      wptr_q      <= wptr_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_rows == '0) ? DONE : READ;
      READ:    if (last_rd) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_drain_d   = 1'b0;
    ram_idx_d   = '0;
    rd_addr_d   = '0;
    rows_left_d = rows_left_q;
    wptr_d      = wptr_q;

    if (accept) begin
      o_drain_d   = 1'b1;
      rd_addr_d   = o_base_addr;
      rows_left_d = num_rows - 1'b1;
      wptr_d      = bram_base;
    end else if (state_q == READ && !last_rd) begin
      o_drain_d = 1'b1;
      if (idx_wrap) begin
        rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
        rows_left_d = rows_left_q - 1'b1;
      end else begin
        ram_idx_d = ram_idx_q + IDX_W'(1);
        rd_addr_d = rd_addr_q;
      end
    end

    // Each read lands one cycle later as a write at the running byte pointer.
    wr_en_d   = o_drain_q;
    wr_addr_d = o_drain_q ? wptr_q : 32'h0;
    if (o_drain_q) wptr_d = wptr_q + 32'd4;

    busy_d = (state_d == READ) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  assign o_drain         = o_drain_q;
  assign o_ram_idx       = ram_idx_q;
  assign o_read_addr     = rd_addr_q;
  assign addr_o_bram     = wr_addr_q;
  assign enable_o_bram   = wr_en_q;
  assign w_enable_o_bram = {4{wr_en_q}};
  assign data_in_o_bram  = o_rdata;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_o_drain_ctrl.sv
// Scoreboard bench for o_drain_ctrl: stimulus pushes expected writes and done
// cycles; a negedge monitor pops and compares whenever the DUT writes or finishes.
module tb_o_drain_ctrl;
  localparam int M  = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] o_base_addr;
  logic [AW:0]   num_rows;
  logic [31:0]   bram_base;
  logic          o_drain;
  logic [2:0]    o_ram_idx;
  logic [AW-1:0] o_read_addr;
  logic [31:0]   o_rdata = 32'h0;
  logic [31:0]   addr_o_bram;
  logic          enable_o_bram;
  logic [3:0]    w_enable_o_bram;
  logic [31:0]   data_in_o_bram;
  logic          busy;
  logic          done;

  o_drain_ctrl #(.ARRAY_M(M), .RAM_SIZE(1024)) dut (
    .clk(clk), .reset(reset), .start(start),
    .o_base_addr(o_base_addr), .num_rows(num_rows), .bram_base(bram_base),
    .o_drain(o_drain), .o_ram_idx(o_ram_idx), .o_read_addr(o_read_addr),
    .o_rdata(o_rdata), .addr_o_bram(addr_o_bram), .enable_o_bram(enable_o_bram),
    .w_enable_o_bram(w_enable_o_bram), .data_in_o_bram(data_in_o_bram),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // O_buffer model: data tagged with the RAM index and row address that was read.
  always @(posedge clk) begin
    if (o_drain) o_rdata <= {16'(o_ram_idx), 16'(o_read_addr)};
    else         o_rdata <= 32'hDEADBEEF;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    int  dc;
    if (enable_o_bram === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                 addr_o_bram, data_in_o_bram, cyc);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", addr_o_bram, e.a);
        chk("wr_data", data_in_o_bram, e.d);
        chk("wr_be", 32'(w_enable_o_bram), 32'hF);
      end
    end else if (w_enable_o_bram !== 4'h0) begin
      checks++; errors++;
      $display("FAIL idle_be: got 0x%0h, expected 0x0 (cycle %0d)", w_enable_o_bram, cyc);
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        dc = dq.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  task automatic issue_start(input logic [AW-1:0] base, input logic [AW:0] rows,
                             input logic [31:0] bram, input int n_wr, input bit exp_done,
                             output int c);
    wr_t e;
    int  r, i;
    logic [AW-1:0] ra;
    @(negedge clk);
    c = cyc;
    start = 1'b1; o_base_addr = base; num_rows = rows; bram_base = bram;
    for (int k = 0; k < n_wr; k++) begin
      r   = k / M;
      i   = k % M;
      ra  = AW'((int'(base) + r) % 1024);
      e.a = bram + 32'(4 * k);
      e.d = {16'(i), 16'(ra)};
      wq.push_back(e);
    end
    if (exp_done) dq.push_back((rows == 0) ? c + 1 : c + int'(rows) * M + 2);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int t = 0;
    while ((wq.size() != 0 || dq.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d writes and %0d done pulses outstanding, expected 0",
               name, wq.size(), dq.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c, c2;
    bit seen;
    reset = 1'b1; start = 1'b0; o_base_addr = '0; num_rows = '0; bram_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_o_drain", 32'(o_drain), 0);
    chk("rst_ram_idx", 32'(o_ram_idx), 0);
    chk("rst_read_addr", 32'(o_read_addr), 0);
    chk("rst_bram_addr", addr_o_bram, 0);
    chk("rst_enable", 32'(enable_o_bram), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic drain
    issue_start(10'd5, 11'd2, 32'h100, 16, 1'b1, c);
    chk("basic_busy_c1", 32'(busy), 1);
    while (cyc < c + 17) @(negedge clk);
    chk("basic_flush_busy", 32'(busy), 1);
    chk("basic_flush_drain", 32'(o_drain), 0);
    @(negedge clk);
    chk("basic_done_busy", 32'(busy), 0);
    chk("basic_done", 32'(done), 1);
    wait_drained("basic_drain", 40);

    // Row address wrap
    issue_start(10'd1022, 11'd3, 32'h2000, 24, 1'b1, c);
    wait_drained("wrap_drain", 60);

    // Zero rows
    issue_start(10'd7, 11'd0, 32'h3000, 0, 1'b1, c);
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (busy !== 1'b0 || o_drain !== 1'b0 || enable_o_bram !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("zero_no_activity", 32'(seen), 0);
    wait_drained("zero_drain", 5);

    // Start while busy is ignored
    issue_start(10'd10, 11'd2, 32'h400, 16, 1'b1, c);
    while (cyc < c + 5) @(negedge clk);
    start = 1'b1; o_base_addr = 10'd100; num_rows = 11'd4; bram_base = 32'h9000;
    @(negedge clk);
    start = 1'b0;
    wait_drained("busy_start_drain", 40);
    repeat (10) @(negedge clk);

    // Reset mid-drain: writes 0..4 land before reset takes effect
    issue_start(10'd200, 11'd4, 32'h500, 5, 1'b0, c);
    while (cyc < c + 6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_o_drain", 32'(o_drain), 0);
    chk("midrst_ram_idx", 32'(o_ram_idx), 0);
    chk("midrst_read_addr", 32'(o_read_addr), 0);
    chk("midrst_bram_addr", addr_o_bram, 0);
    chk("midrst_enable", 32'(enable_o_bram), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    wait_drained("midrst_drain", 1);

    // Back-to-back: second start in the first IDLE cycle
    issue_start(10'd0, 11'd1, 32'h600, 8, 1'b1, c);
    while (cyc < c + 10) @(negedge clk);
    issue_start(10'd50, 11'd1, 32'h700, 8, 1'b1, c2);
    chk("b2b_start_cycle", c2, c + 11);
    chk("b2b_busy", 32'(busy), 1);
    wait_drained("b2b_drain", 40);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
